// File: rtl/ahb_mgr_arbiter.sv
// Round-robin arbiter/mux letting NUM_MGR AHB managers share one subordinate port.
// Grants only at burst boundaries and caps how long one manager holds the bus under contention.
module ahb_mgr_arbiter #(
  parameter int unsigned NUM_MGR  = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic [NUM_MGR-1:0]        req,
  input  logic [2*NUM_MGR-1:0]      mTrans,
  input  logic [ADDR_W*NUM_MGR-1:0] mAddr,
  input  logic [NUM_MGR-1:0]        mWrite,
  input  logic [3*NUM_MGR-1:0]      mSize,
  input  logic [3*NUM_MGR-1:0]      mBurst,
  input  logic [DATA_W*NUM_MGR-1:0] mWData,
  output logic [NUM_MGR-1:0]        grant,
  output logic [NUM_MGR-1:0]        mReady,
  output logic [NUM_MGR-1:0]        mResp,
  output logic [DATA_W-1:0]         mRData,
  output logic [1:0]                sTrans,
  output logic [ADDR_W-1:0]         sAddr,
  output logic                      sWrite,
  output logic [2:0]                sSize,
  output logic [2:0]                sBurst,
  output logic [DATA_W-1:0]         sWData,
  input  logic                      sReady,
  input  logic                      sResp,
  input  logic [DATA_W-1:0]         sRData
);

  localparam int unsigned IDX_W  = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int unsigned BEAT_W = 4;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_MGR-1:0]  r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic                r_dvalid;
  logic [IDX_W-1:0]    r_downer;
  logic [BEAT_W-1:0]   r_beats;
  logic [HOLD_W-1:0]   r_hold;

  logic [1:0]          w_trans_a [NUM_MGR];
  logic [ADDR_W-1:0]   w_addr_a  [NUM_MGR];
  logic [2:0]          w_size_a  [NUM_MGR];
  logic [2:0]          w_burst_a [NUM_MGR];
  logic [DATA_W-1:0]   w_wdata_a [NUM_MGR];

  logic                w_nonseq, w_seq, w_fixed, w_boundary;
  logic [HOLD_W-1:0]   w_hold_inc;
  logic                w_hold_cap, w_others, w_rearb;
  logic [BEAT_W-1:0]   w_beats_load;
  logic                w_sel_found;
  logic [IDX_W-1:0]    w_sel_idx, w_cand;

  for (genvar g = 0; g < NUM_MGR; g++) begin : g_unpack
    assign w_trans_a[g] = mTrans[2*g +: 2];
    assign w_addr_a[g]  = mAddr[ADDR_W*g +: ADDR_W];
    assign w_size_a[g]  = mSize[3*g +: 3];
    assign w_burst_a[g] = mBurst[3*g +: 3];
    assign w_wdata_a[g] = mWData[DATA_W*g +: DATA_W];
  end

  // Address phase follows the granted manager; r_last is the owner while granted.
  always_comb begin
    sTrans = TR_IDLE;
    sAddr  = '0;
    sWrite = 1'b0;
    sSize  = '0;
    sBurst = '0;
    if (r_state == ST_GRANTED) begin
      sTrans = w_trans_a[r_last];
      sAddr  = w_addr_a[r_last];
      sWrite = mWrite[r_last];
      sSize  = w_size_a[r_last];
      sBurst = w_burst_a[r_last];
    end
  end

  assign sWData = r_dvalid ? w_wdata_a[r_downer] : '0;
  assign mReady = {NUM_MGR{sReady}};
  assign mRData = sRData;
  assign grant  = r_grant;

  always_comb begin
    mResp = '0;
    if (r_dvalid) mResp[r_downer] = sResp;
  end

  assign w_nonseq   = (sTrans == TR_NONSEQ);
  assign w_seq      = (sTrans == TR_SEQ);
  assign w_fixed    = (sBurst != BU_SINGLE) && (sBurst != BU_INCR);
  assign w_boundary = sReady && ((sTrans == TR_IDLE) ||
                                 (w_nonseq && (sBurst == BU_SINGLE)) ||
                                 (w_seq && w_fixed && (r_beats == BEAT_W'(1))));

  // Hold count as it will stand after this edge, so the cap bites on the MAX_HOLD-th NONSEQ.
  assign w_hold_inc = (sReady && w_nonseq && (r_hold != HOLD_W'(MAX_HOLD)))
                      ? r_hold + HOLD_W'(1) : r_hold;
  assign w_hold_cap = (w_hold_inc == HOLD_W'(MAX_HOLD));
  assign w_others   = |(req & ~r_grant);

  always_comb begin
    case (sBurst)
      3'd2, 3'd3: w_beats_load = BEAT_W'(3);
      3'd4, 3'd5: w_beats_load = BEAT_W'(7);
      3'd6, 3'd7: w_beats_load = BEAT_W'(15);
      default:    w_beats_load = '0;
    endcase
  end

  // Round-robin: scan from r_last+1 upward; descending loop leaves the nearest requester.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = NUM_MGR; k >= 1; k--) begin
      w_cand = IDX_W'((32'(r_last) + k) % NUM_MGR);
      if (req[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_rearb     = 1'b0;
    case (r_state)
      ST_IDLE:    w_rearb = sReady && (|req);
      ST_GRANTED: w_rearb = w_boundary && (!req[r_last] || (w_hold_cap && w_others));
      default:    w_rearb = 1'b0;
    endcase
    if (w_rearb) begin
      w_grant_nxt = '0;
      if (w_sel_found) begin
        w_state_nxt            = ST_GRANTED;
        w_grant_nxt[w_sel_idx] = 1'b1;
        w_last_nxt             = w_sel_idx;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_MGR - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Data-phase owner, beat counter and hold counter; sReady low freezes them all.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_dvalid <= 1'b0;
      r_downer <= '0;
      r_beats  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_grant_nxt != r_grant) r_hold <= '0;
      else                        r_hold <= w_hold_inc;
      if (sReady) begin
        r_dvalid <= w_nonseq || w_seq;
        r_downer <= r_last;
        if (w_nonseq)                        r_beats <= w_beats_load;
        else if (w_seq && (r_beats != '0))   r_beats <= r_beats - BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_mgr_arbiter.sv
// Scoreboard bench for ahb_mgr_arbiter: directed scenarios plus random traffic
// checked each cycle against a transaction-level reference model.
module tb_ahb_mgr_arbiter;

  localparam int NUM  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXH = 4;

  logic                clk = 1'b0;
  logic                nReset;
  logic [NUM-1:0]      req;
  logic [2*NUM-1:0]    mTrans;
  logic [AW*NUM-1:0]   mAddr;
  logic [NUM-1:0]      mWrite;
  logic [3*NUM-1:0]    mSize;
  logic [3*NUM-1:0]    mBurst;
  logic [DW*NUM-1:0]   mWData;
  logic [NUM-1:0]      grant, mReady, mResp;
  logic [DW-1:0]       mRData;
  logic [1:0]          sTrans;
  logic [AW-1:0]       sAddr;
  logic                sWrite;
  logic [2:0]          sSize, sBurst;
  logic [DW-1:0]       sWData;
  logic                sReady, sResp;
  logic [DW-1:0]       sRData;

  always #5 clk = ~clk;

  ahb_mgr_arbiter #(.NUM_MGR(NUM), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .nReset(nReset), .req(req), .mTrans(mTrans), .mAddr(mAddr),
    .mWrite(mWrite), .mSize(mSize), .mBurst(mBurst), .mWData(mWData),
    .grant(grant), .mReady(mReady), .mResp(mResp), .mRData(mRData),
    .sTrans(sTrans), .sAddr(sAddr), .sWrite(sWrite), .sSize(sSize), .sBurst(sBurst),
    .sWData(sWData), .sReady(sReady), .sResp(sResp), .sRData(sRData)
  );

  typedef struct {
    logic [NUM-1:0] grant;
    logic [1:0]     trans;
    logic [AW-1:0]  addr;
    logic           wr;
    logic [2:0]     size;
    logic [2:0]     burst;
    logic [DW-1:0]  wdata;
    logic [NUM-1:0] resp;
    logic [NUM-1:0] ready;
    logic [DW-1:0]  rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: owner index (-1 = none), data-phase owner, beats left, NONSEQ tally.
  int m_owner, m_last, m_downer, m_beats, m_hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = NUM - 1; m_downer = -1; m_beats = 0; m_hold = 0;
  endtask

  task automatic compute_exp(output exp_t e);
    e.grant = '0; e.trans = 2'd0; e.addr = '0; e.wr = 1'b0; e.size = 3'd0; e.burst = 3'd0;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.trans = mTrans[2*m_owner +: 2];
      e.addr  = mAddr[AW*m_owner +: AW];
      e.wr    = mWrite[m_owner];
      e.size  = mSize[3*m_owner +: 3];
      e.burst = mBurst[3*m_owner +: 3];
    end
    e.wdata = (m_downer >= 0) ? mWData[DW*m_downer +: DW] : '0;
    e.resp  = '0;
    if (m_downer >= 0) e.resp[m_downer] = sResp;
    e.ready = {NUM{sReady}};
    e.rdata = sRData;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    exp_t e;
    bit   bnd, rearb;
    int   hold_after, win, c;
    if (!sReady) return;
    compute_exp(e);
    bnd = (e.trans == 2'd0) || (e.trans == 2'd2 && e.burst == 3'd0) ||
          (e.trans == 2'd3 && e.burst >= 3'd2 && m_beats == 1);
    hold_after = (e.trans == 2'd2) ? ((m_hold + 1 > MAXH) ? MAXH : m_hold + 1) : m_hold;
    if (m_owner < 0) rearb = (req != '0);
    else rearb = bnd && (!req[m_owner] || (hold_after == MAXH && (req & ~e.grant) != '0));
    m_downer = (e.trans >= 2'd2) ? m_owner : -1;
    if (e.trans == 2'd2) m_beats = burst_beats(e.burst) - 1;
    else if (e.trans == 2'd3 && m_beats > 0) m_beats--;
    m_hold = hold_after;
    if (rearb) begin
      win = -1;
      for (int k = 1; k <= NUM; k++) begin
        c = (m_last + k) % NUM;
        if (win < 0 && req[c]) win = c;
      end
      if (win != m_owner) m_hold = 0;
      m_owner = win;
      if (win >= 0) m_last = win;
    end
  endtask

  // One bus cycle: record the expectation for the current inputs, then cross the edge.
  task automatic step();
    exp_t e;
    compute_exp(e);
    exp_q.push_back(e);
    @(posedge clk);
    if (nReset) model_step();
    #1;
  endtask

  task automatic set_mgr(input int i, input logic [1:0] t, input logic [2:0] b,
                         input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    mTrans[2*i +: 2] = t;
    mBurst[3*i +: 3] = b;
    mAddr[AW*i +: AW] = a;
    mWrite[i] = w;
    mSize[3*i +: 3] = 3'd2;
    mWData[DW*i +: DW] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NUM; i++) set_mgr(i, 2'd0, 3'd0, '0, 1'b0, '0);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM; i++) begin
      int r;
      r = $urandom_range(0, 9);
      req[i] = ($urandom_range(0, 3) != 0);
      mTrans[2*i +: 2] = (r < 3) ? 2'd0 : (r == 3) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
      mBurst[3*i +: 3] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      mAddr[AW*i +: AW] = AW'($urandom);
      mWrite[i] = 1'($urandom_range(0, 1));
      mSize[3*i +: 3] = 3'($urandom_range(0, 7));
      mWData[DW*i +: DW] = DW'($urandom);
    end
    sReady = ($urandom_range(0, 4) != 0);
    sResp  = ($urandom_range(0, 6) == 0);
    sRData = DW'($urandom);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("grant",  64'(grant),  64'(e.grant));
      chk("sTrans", 64'(sTrans), 64'(e.trans));
      chk("sAddr",  64'(sAddr),  64'(e.addr));
      chk("sWrite", 64'(sWrite), 64'(e.wr));
      chk("sSize",  64'(sSize),  64'(e.size));
      chk("sBurst", 64'(sBurst), 64'(e.burst));
      chk("sWData", 64'(sWData), 64'(e.wdata));
      chk("mResp",  64'(mResp),  64'(e.resp));
      chk("mReady", 64'(mReady), 64'(e.ready));
      chk("mRData", 64'(mRData), 64'(e.rdata));
    end
  end

  initial begin
    nReset = 1'b0; req = '0; sReady = 1'b1; sResp = 1'b0; sRData = '0;
    idle_all();
    model_reset();
    @(posedge clk); #1;
    step(); step();
    nReset = 1'b1;
    step();

    // Single transfer from manager 0
    req = 4'b0001; set_mgr(0, 2'd2, 3'd0, 32'h100, 1'b1, 32'hA0A0_0001); step();
    chk("d1_grant", 64'(grant), 64'h1);
    chk("d1_addr", 64'(sAddr), 64'h100);
    req = '0; sResp = 1'b1; step();
    chk("d1_resp", 64'(mResp), 64'h1);
    chk("d1_release", 64'(grant), 64'h0);
    idle_all(); sResp = 1'b0; step();

    // Two simultaneous requesters
    req = 4'b0110;
    set_mgr(1, 2'd2, 3'd0, 32'h200, 1'b0, 32'h0);
    set_mgr(2, 2'd2, 3'd0, 32'h300, 1'b1, 32'hB0B0_0002); step();
    chk("d2_first", 64'(grant), 64'h2);
    step();
    chk("d2_keep", 64'(grant), 64'h2);
    req = 4'b0100; set_mgr(1, 2'd0, 3'd0, '0, 1'b0, '0); step();
    chk("d2_second", 64'(grant), 64'h4);
    idle_all(); req = '0; step(); step();

    // INCR4 is not interrupted by a new requester
    req = 4'b0001; set_mgr(0, 2'd2, 3'd3, 32'h400, 1'b1, 32'hD000_0000); step();
    step();
    req = 4'b0101; set_mgr(0, 2'd3, 3'd3, 32'h404, 1'b1, 32'hD000_0001); step();
    chk("d3_beat2", 64'(grant), 64'h1);
    set_mgr(0, 2'd3, 3'd3, 32'h408, 1'b1, 32'hD000_0002); step();
    chk("d3_beat3", 64'(grant), 64'h1);
    req = 4'b0100; set_mgr(0, 2'd3, 3'd3, 32'h40C, 1'b1, 32'hD000_0003); step();
    chk("d3_handover", 64'(grant), 64'h4);
    chk("d3_wdata", 64'(sWData), 64'hD000_0003);
    idle_all(); req = '0; step(); step();

    // INCR with BUSY: handover only on IDLE
    req = 4'b0001; set_mgr(0, 2'd2, 3'd1, 32'h500, 1'b0, '0); step();
    req = 4'b0011; step();
    set_mgr(0, 2'd1, 3'd1, 32'h504, 1'b0, '0); step();
    chk("d4_busy", 64'(grant), 64'h1);
    set_mgr(0, 2'd3, 3'd1, 32'h504, 1'b0, '0); step();
    chk("d4_seq", 64'(grant), 64'h1);
    req = 4'b0010; set_mgr(0, 2'd0, 3'd1, '0, 1'b0, '0); step();
    chk("d4_idle", 64'(grant), 64'h2);
    idle_all(); req = '0; step(); step();

    // Hold cap with a competing requester, then without one
    req = 4'b1000; set_mgr(3, 2'd2, 3'd0, 32'h600, 1'b1, 32'hC000_0003); step();
    chk("d5_grant3", 64'(grant), 64'h8);
    req = 4'b1001;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 3) chk("d5_before_cap", 64'(grant), 64'h8);
    end
    chk("d5_cap", 64'(grant), 64'h1);
    req = 4'b1000; step();
    chk("d5_back3", 64'(grant), 64'h8);
    for (int n = 1; n <= 5; n++) step();
    chk("d5_keep_alone", 64'(grant), 64'h8);
    idle_all(); req = '0; step(); step();

    // Two-cycle ERROR response
    req = 4'b0010; set_mgr(1, 2'd2, 3'd0, 32'h700, 1'b0, '0); step();
    chk("d6_grant1", 64'(grant), 64'h2);
    step();
    req = 4'b0100; set_mgr(1, 2'd0, 3'd0, '0, 1'b0, '0); sResp = 1'b1; sReady = 1'b0; step();
    chk("d6_err1_grant", 64'(grant), 64'h2);
    chk("d6_err1_resp", 64'(mResp), 64'h2);
    sReady = 1'b1; step();
    chk("d6_rearb", 64'(grant), 64'h4);
    chk("d6_resp_after", 64'(mResp), 64'h0);
    idle_all(); req = '0; sResp = 1'b0; step(); step();

    // Random traffic with one asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs();
      if (cyc == 1500) begin
        nReset = 1'b0;
        model_reset();
        step(); step();
        nReset = 1'b1;
      end
      step();
    end

    idle_all(); req = '0; sReady = 1'b1; sResp = 1'b0;
    step(); step();
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
